// File: rtl/alu4_seq_if.sv
// Command/status bus between the tile command logic and the alu4 nibble sequencer.
// Master issues start/cmd/operands; slave reports busy/done/result/flags.
interface alu4_seq_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   cmd;
  logic         cin;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         flag_c;
  logic         flag_z;
  logic         flag_v;

  modport master (
    output start, cmd, cin, opa, opb,
    input  busy, done, result, flag_c, flag_z, flag_v
  );

  modport slave (
    input  start, cmd, cin, opa, opb,
    output busy, done, result, flag_c, flag_z, flag_v
  );
endinterface

// File: rtl/alu4_seq.sv
// Nibble-serial sequencer driving one alu4: 4*NIBBLES-bit ADD/ADC/SUB/SBC/INC/CMP.
// Latency NIBBLES+1 cycles from start to done; ena=0 freezes everything, start is ignored while busy.
module alu4_seq #(
  parameter int         NIBBLES    = 4,
  parameter logic [1:0] ALU_OP_ADD = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  alu4_seq_if.slave  bus,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_bmode,
  output logic       alu_b_inv,
  output logic       alu_y,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_s,
  input  logic       alu_c,
  input  logic       alu_overflow
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_ADC = 3'b001;
  localparam logic [2:0] CMD_SUB = 3'b010;
  localparam logic [2:0] CMD_SBC = 3'b011;
  localparam logic [2:0] CMD_INC = 3'b100;
  localparam logic [2:0] CMD_CMP = 3'b101;

  localparam logic [1:0] BMODE_NORMAL = 2'b00;
  localparam logic [1:0] BMODE_ONE    = 2'b01;
  localparam logic [1:0] BMODE_CLEAR  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cy_q, cy_d;
  logic          zacc_q, zacc_d;
  logic          v_q, v_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  result_q, result_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_v_q, flag_v_d;

  logic reserved;
  assign reserved = (cmd_q[2:1] == 2'b11);

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    zacc_d    = zacc_q;
    v_d       = v_q;
    work_d    = work_q;
    result_d  = result_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    flag_v_d  = flag_v_q;
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    alu_bmode = BMODE_NORMAL;
    alu_b_inv = 1'b0;
    alu_y     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena && bus.start) begin
          opa_d  = bus.opa;
          opb_d  = bus.opb;
          cmd_d  = bus.cmd;
          idx_d  = '0;
          zacc_d = 1'b1;
          case (bus.cmd)
            CMD_ADD, CMD_INC: cy_d = 1'b0;
            CMD_ADC, CMD_SBC: cy_d = bus.cin;
            default:          cy_d = 1'b1;
          endcase
          state_d = (bus.cmd[2:1] == 2'b11) ? DONE : RUN;
        end
      end

      RUN: begin
        alu_a = opa_q[4*idx_q +: 4];
        alu_y = cy_q;
        case (cmd_q)
          CMD_ADD, CMD_ADC: alu_b = opb_q[4*idx_q +: 4];
          CMD_SUB, CMD_SBC, CMD_CMP: begin
            alu_b     = opb_q[4*idx_q +: 4];
            alu_b_inv = 1'b1;
          end
          // INC adds a constant 1 in the LSB nibble, then only ripples the carry.
          CMD_INC: alu_bmode = (idx_q == '0) ? BMODE_ONE : BMODE_CLEAR;
          default: ;
        endcase
        if (ena) begin
          work_d[4*idx_q +: 4] = alu_s;
          cy_d   = alu_c;
          zacc_d = zacc_q & (alu_s == 4'd0);
          if (idx_q == IW'(NIBBLES - 1)) begin
            v_d     = alu_overflow;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        if (ena) begin
          state_d = IDLE;
          if (!reserved) begin
            flag_c_d = cy_q;
            flag_z_d = zacc_q;
            flag_v_d = v_q;
            if (cmd_q != CMD_CMP) result_d = work_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      cmd_q    <= '0;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      zacc_q   <= 1'b0;
      v_q      <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      cy_q     <= cy_d;
      zacc_q   <= zacc_d;
      v_q      <= v_d;
      work_q   <= work_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
    end
  end

  assign alu_op     = ALU_OP_ADD;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_v = flag_v_q;
endmodule

// File: tb/tb_alu4_seq.sv
// Bench for alu4_seq at NIBBLES=4 with a behavioural alu4 on the ALU pins and a
// wide-arithmetic reference model for results and flags.
module tb_alu4_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] alu_a, alu_b, alu_s;
  logic [1:0] alu_bmode, alu_op;
  logic       alu_b_inv, alu_y, alu_c, alu_ovf;

  int checks   = 0;
  int failures = 0;

  alu4_seq_if #(.NIBBLES(4)) bus ();

  alu4_seq #(.NIBBLES(4), .ALU_OP_ADD(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_bmode(alu_bmode), .alu_b_inv(alu_b_inv),
    .alu_y(alu_y), .alu_op(alu_op), .alu_s(alu_s), .alu_c(alu_c), .alu_overflow(alu_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural alu4 in add mode.
  logic [3:0] m_bx, m_bp;
  logic [4:0] m_sum;
  always_comb begin
    case (alu_bmode)
      2'b00:   m_bx = alu_b;
      2'b01:   m_bx = 4'd1;
      2'b10:   m_bx = 4'd0;
      default: m_bx = alu_b >> 1;
    endcase
    m_bp    = alu_b_inv ? ~m_bx : m_bx;
    m_sum   = {1'b0, alu_a} + {1'b0, m_bp} + {4'd0, alu_y};
    alu_s   = m_sum[3:0];
    alu_c   = m_sum[4];
    alu_ovf = (alu_a[3] == m_bp[3]) && (m_sum[3] != alu_a[3]);
  end

  // Expected committed state.
  logic [15:0] exp_result;
  logic        exp_c, exp_z, exp_v;

  function automatic logic [18:0] model(input logic [2:0] c, input logic [15:0] a, b,
                                        input logic ci);
    logic [15:0] bp;
    logic        y;
    logic [16:0] s;
    case (c)
      3'd0:       begin bp = b;     y = 1'b0; end
      3'd1:       begin bp = b;     y = ci;   end
      3'd2, 3'd5: begin bp = ~b;    y = 1'b1; end
      3'd3:       begin bp = ~b;    y = ci;   end
      default:    begin bp = 16'd1; y = 1'b0; end
    endcase
    s = {1'b0, a} + {1'b0, bp} + {16'd0, y};
    return {s[16], (s[15:0] == 16'd0), (a[15] == bp[15]) && (s[15] != a[15]), s[15:0]};
  endfunction

  task automatic apply_model(input logic [2:0] c, input logic [15:0] a, b, input logic ci);
    logic [18:0] m;
    m = model(c, a, b, ci);
    if (c[2:1] != 2'b11) begin
      {exp_c, exp_z, exp_v} = m[18:16];
      if (c != 3'd5) exp_result = m[15:0];
    end
  endtask

  // Per-command observations filled in by run_cmd.
  int         lat, busy_cnt, bad_bm;
  logic [1:0] bm_log [0:15];

  task automatic run_cmd(input logic [2:0] c, input logic [15:0] a, b, input logic ci,
                         input int stall_at, input int stall_len, input int pulse_at);
    bus.start = 1'b1; bus.cmd = c; bus.opa = a; bus.opb = b; bus.cin = ci; ena = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; busy_cnt = 0; bad_bm = 0;
    while (lat < 40) begin
      if (lat < 16) bm_log[lat] = alu_bmode;
      if (alu_bmode == 2'b11) bad_bm++;
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
      ena       = !(lat >= stall_at && lat < stall_at + stall_len);
      bus.start = (lat == pulse_at);
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    apply_model(c, a, b, ci);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_z, bus.flag_v,
         alu_a, alu_b, alu_bmode, alu_b_inv, alu_y, alu_op} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h flags=%b%b%b alu_a=%h alu_b=%h op=%b expected all zero",
               bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_z, bus.flag_v, alu_a, alu_b, alu_op);
    end
    rst_n = 1'b1;
    exp_result = 16'd0; exp_c = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    run_cmd(3'd0, 16'h1234, 16'h0FCD, 1'b0, 99, 0, -1);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL add_latency: got %0d expected 5", lat); end
    checks++;
    if (busy_cnt !== 5) begin failures++; $display("FAIL add_busy_cycles: got %0d expected 5", busy_cnt); end
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {16'h2201, 3'b000}) begin
      failures++;
      $display("FAIL add_result: got %h c%b z%b v%b expected 2201 c0 z0 v0",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v);
    end
    checks++;
    if ({bus.done, bus.busy, alu_a, alu_b, alu_bmode, alu_b_inv, alu_y} !== '0) begin
      failures++;
      $display("FAIL idle_drive: got done=%b busy=%b a=%h b=%h bm=%b inv=%b y=%b expected zeros",
               bus.done, bus.busy, alu_a, alu_b, alu_bmode, alu_b_inv, alu_y);
    end
  endtask

  task automatic test_sub_equal;
    run_cmd(3'd2, 16'h0005, 16'h0005, 1'b0, 99, 0, -1);
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {16'h0000, 3'b110}) begin
      failures++;
      $display("FAIL sub_equal: got %h c%b z%b v%b expected 0000 c1 z1 v0",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v);
    end
  endtask

  task automatic test_overflow;
    run_cmd(3'd0, 16'h7FFF, 16'h0001, 1'b0, 99, 0, -1);
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {16'h8000, 3'b001}) begin
      failures++;
      $display("FAIL add_overflow: got %h c%b z%b v%b expected 8000 c0 z0 v1",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v);
    end
    run_cmd(3'd3, 16'h0000, 16'h0000, 1'b0, 99, 0, -1);
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {16'hFFFF, 3'b000}) begin
      failures++;
      $display("FAIL sbc_borrow: got %h c%b z%b v%b expected ffff c0 z0 v0",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v);
    end
  endtask

  task automatic test_inc_wrap;
    run_cmd(3'd4, 16'hFFFF, 16'h1234, 1'b1, 99, 0, -1);
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {16'h0000, 3'b110}) begin
      failures++;
      $display("FAIL inc_wrap: got %h c%b z%b v%b expected 0000 c1 z1 v0",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v);
    end
    checks++;
    if ({bm_log[1], bm_log[2], bm_log[3], bm_log[4]} !== 8'b01_10_10_10) begin
      failures++;
      $display("FAIL inc_bmode: got %b %b %b %b expected 01 10 10 10",
               bm_log[1], bm_log[2], bm_log[3], bm_log[4]);
    end
  endtask

  task automatic test_cmp_ignored_start;
    int extra_done;
    run_cmd(3'd5, 16'h0003, 16'h0004, 1'b0, 99, 0, 2);
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL cmp_flags: got %h c%b z%b v%b expected 0000 c0 z0 v0",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v);
    end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL cmp_latency: got %0d expected 5", lat); end
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done || bus.busy) extra_done++;
      @(negedge clk);
    end
    checks++;
    if (extra_done !== 0) begin
      failures++;
      $display("FAIL ignored_start: got %0d busy/done cycles after command expected 0", extra_done);
    end
  endtask

  task automatic test_stall_reset;
    run_cmd(3'd0, 16'hA5A5, 16'h1111, 1'b0, 2, 3, -1);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL stall_latency: got %0d expected 8", lat); end
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {16'hB6B6, 3'b000}) begin
      failures++;
      $display("FAIL stall_result: got %h c%b z%b v%b expected b6b6 c0 z0 v0",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v);
    end
    bus.start = 1'b1; bus.cmd = 3'd0; bus.opa = 16'hFFFF; bus.opb = 16'hFFFF; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_z, bus.flag_v,
         alu_a, alu_b, alu_bmode, alu_b_inv, alu_y, alu_op} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: got busy=%b done=%b result=%h flags=%b%b%b alu_a=%h alu_b=%h expected all zero",
               bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_z, bus.flag_v, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_result = 16'd0; exp_c = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
    @(negedge clk);
    run_cmd(3'd0, 16'h0001, 16'h0001, 1'b0, 99, 0, -1);
    checks++;
    if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v, lat} !== {16'h0002, 3'b000, 32'd5}) begin
      failures++;
      $display("FAIL after_reset_add: got %h c%b z%b v%b lat=%0d expected 0002 c0 z0 v0 lat=5",
               bus.result, bus.flag_c, bus.flag_z, bus.flag_v, lat);
    end
  endtask

  task automatic test_random_back_to_back;
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  c;
      logic [15:0] a, b;
      logic        ci;
      int          s_at, s_len, exp_lat;
      c     = 3'($urandom_range(0, 7));
      a     = 16'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      ci    = 1'($urandom);
      s_at  = $urandom_range(1, 4);
      s_len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      exp_lat = (c[2:1] == 2'b11) ? 1 : 5 + s_len;
      run_cmd(c, a, b, ci, s_at, s_len, 3);
      checks++;
      if ({bus.result, bus.flag_c, bus.flag_z, bus.flag_v} !== {exp_result, exp_c, exp_z, exp_v}) begin
        failures++;
        $display("FAIL rand_result[%0d] cmd=%0d a=%h b=%h cin=%b: got %h c%b z%b v%b expected %h c%b z%b v%b",
                 n, c, a, b, ci, bus.result, bus.flag_c, bus.flag_z, bus.flag_v,
                 exp_result, exp_c, exp_z, exp_v);
      end
      checks++;
      if (lat !== exp_lat || bad_bm !== 0) begin
        failures++;
        $display("FAIL rand_timing[%0d] cmd=%0d: got lat=%0d bmode11=%0d expected lat=%0d bmode11=0",
                 n, c, lat, bad_bm, exp_lat);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0;
    bus.start = 1'b0; bus.cmd = 3'd0; bus.cin = 1'b0; bus.opa = 16'd0; bus.opb = 16'd0;
    test_reset();
    test_add();
    test_sub_equal();
    test_overflow();
    test_inc_wrap();
    test_cmp_ignored_start();
    test_stall_reset();
    test_random_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu4_seq.md
# alu4_seq

Multi-cycle sequencer that runs the 4-bit ALU datapath (`alu4`) nibble-serially to perform `4*NIBBLES`-bit arithmetic. It latches wide operands and a command, then steps the ALU one nibble per cycle, LSB first, chaining carry through `y`. It collects the result and the C/Z/V flags and signals completion with a single-cycle `done` pulse. It sits between the tile's command inputs and a single `alu4` instance, and owns all of that instance's input pins.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; data width is `W = 4*NIBBLES`. Minimum value is 2.
- `ALU_OP_ADD`, default 2'b00: the alu4 `op[1:0]` code that computes `a + b' + y`, where `b'` is b after b-mode and inversion. It is driven constantly.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: design enable. While low, the FSM and all registers hold.
- `start` in 1: command request. It is sampled only in IDLE with `ena=1`.
- `cmd` in 3: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 INC, 101 CMP, 11x reserved.
- `cin` in 1: carry-in for ADC/SBC, latched with `start`.
- `opa`, `opb` in W: operands, latched with `start`.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse in DONE.
- `result` out W: last committed result.
- `flag_c`, `flag_z`, `flag_v` out 1: last committed flags.
- `alu_a`, `alu_b` out 4: ALU operand nibbles.
- `alu_bmode` out 2: ALU b-mode; 00 NORMAL, 01 ONE, 10 CLEAR. 11 (LSR) is never driven.
- `alu_b_inv` out 1: ALU b-invert.
- `alu_y` out 1: ALU carry-in.
- `alu_op` out 2: always `ALU_OP_ADD`.
- `alu_s` in 4, `alu_c` in 1, `alu_overflow` in 1: ALU results. The ALU is combinational within the same cycle.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN:** on `start & ena`. On that edge:
  - latch `opa`, `opb`, `cmd`;
  - set nibble index `i=0`;
  - load carry register `cy` with y0: 0 for ADD/INC, `cin` for ADC/SBC, 1 for SUB/CMP;
  - set zero accumulator `zacc=1`.
- **Reserved cmd:** goes IDLE → DONE directly. `result` and flags are unchanged.
- **RUN, per cycle (when `ena=1`):**
  - Drive `alu_a = opa_l[4i+3:4i]` and `alu_y = cy`.
  - ADD/ADC: `alu_b = opb_l` nibble i, NORMAL, `b_inv=0`.
  - SUB/SBC/CMP: `alu_b = opb_l` nibble i, NORMAL, `b_inv=1`.
  - INC: `alu_b = 0`, `b_inv=0`; b-mode is ONE for i=0 and CLEAR for i>0.
  - Clock edge: `work[4i+3:4i] <= alu_s`; `cy <= alu_c`; `zacc <= zacc & (alu_s==0)`. Z is computed from `alu_s`, not from the ALU zero pin.
  - At `i == NIBBLES-1`: capture `v <= alu_overflow` (MSB nibble only) and go to DONE. Otherwise `i <= i+1`.
- **DONE (one cycle when `ena=1`):**
  - `done=1`.
  - Commit `flag_c=cy`, `flag_z=zacc`, `flag_v=v`.
  - Commit `result=work`, except CMP, which leaves `result` unchanged.
  - Next state is IDLE.
- **Carry semantics:** SUB/SBC carry is the not-borrow (`c=1` means `a>=b` unsigned).
- **Idle drive:** outside RUN, `alu_a=alu_b=0`, `alu_bmode=00`, `alu_b_inv=0`, `alu_y=0`.
- **Ignored start:** `start` is ignored in RUN and DONE. It is not queued.
- **Reset (any state, including mid-RUN):**
  - FSM returns to IDLE.
  - All outputs go to 0: `result`, flags, `busy`, `done`, and all `alu_*` pins (`alu_op` = `ALU_OP_ADD`).
  - All internal registers clear.
  - A partial `work` value is never committed.

## Timing
- `start` is sampled at edge E0. RUN occupies cycles 1..NIBBLES and `done` is high in cycle NIBBLES+1. Latency is NIBBLES+1 cycles (5 at default).
- `result` and flags change only at the DONE→IDLE edge; they become visible in the cycle after `done`, and are stable thereafter until the next command.
- Earliest next `start` is in the cycle after DONE (first IDLE cycle), giving one command per NIBBLES+2 cycles.
- Each cycle with `ena=0` stalls the FSM, `i`, `cy`, `zacc`, and `work`. `alu_*` outputs keep their current values. Latency grows by exactly the number of stalled cycles. A `done` pulse held by `ena=0` stays high until a cycle with `ena=1`.
- The `alu_s` → `work` path is single-cycle and combinational through alu4. No pipelining.

## Test plan
All scenarios use NIBBLES=4 with a reference alu4 connected.
- **ADD:** 0x1234 + 0x0FCD → `result` 0x2201, C=0, Z=0, V=0; `done` exactly 5 cycles after `start`; `busy` high for 5 cycles.
- **SUB, equal operands:** 0x0005 − 0x0005 → 0x0000, C=1, Z=1, V=0.
- **Signed overflow:** ADD 0x7FFF + 0x0001 → 0x8000, C=0, Z=0, V=1. Then SBC 0x0000 − 0x0000 with `cin=0` → 0xFFFF, C=0, Z=0, V=0.
- **INC wrap:** INC 0xFFFF → 0x0000, C=1, Z=1. Check `alu_bmode` is 01 in RUN cycle 1 and 10 in RUN cycles 2–4.
- **CMP and ignored start:** CMP 0x0003 vs 0x0004 after INC → `result` stays 0x0000, C=0, Z=0, V=0. A second `start` pulsed mid-RUN produces no extra `done`.
- **Stall and reset:** ADD with `ena=0` for 3 cycles mid-RUN → `done` at cycle 8 with the correct sum. Then assert `rst_n=0` after 2 RUN cycles of a new ADD → all outputs 0 immediately, IDLE; a following ADD 0x0001 + 0x0001 → 0x0002.
